// File: rtl/header_server_pkg.sv
// Shared constants and helpers for the block-header responder.
// The same values are used by sha256d_wrapper for its {block2, addr[3:0]}
// address mapping, so they live in one package.
package header_server_pkg;

  localparam logic [6:0] HDR_BYTES  = 7'd80;  // header length; load pointer saturates here
  localparam logic [4:0] HDR_WORDS  = 5'd20;  // words served; addr >= HDR_WORDS is out of range
  localparam logic [4:0] NONCE_WORD = 5'd19;  // word replaced by the byte-swapped nonce counter
  localparam logic [4:0] BLK2_BASE  = 5'd16;  // first word of the second SHA-256 block

  // The nonce is kept numerically; the header stores it little-endian, so the
  // served word is its byte reversal.
  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/header_server_loader.sv
// Byte-serial header loader: owns the load pointer and hdr_valid, and decodes
// each accepted byte into a word index and a byte position within that word.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   load_clr_i       pointer := 0 (wins over load_we_i)
//   load_we_i        write request for the byte at the pointer
//   rq_i             a read is in progress; a write now collides
//   wr_en_o          byte accepted this cycle
//   wr_word_o        target word (pointer / 4)
//   wr_pos_o         byte position in header order (pointer % 4)
//   collide_o        write dropped because a read was in progress
//   hdr_valid_o      all HDR_BYTES loaded since the last clear/reset
module header_server_loader
  import header_server_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_clr_i,
  input  logic       load_we_i,
  input  logic       rq_i,
  output logic       wr_en_o,
  output logic [4:0] wr_word_o,
  output logic [1:0] wr_pos_o,
  output logic       collide_o,
  output logic       hdr_valid_o
);

  logic [6:0] ptr_q, ptr_d;

  // A full header leaves the pointer parked at HDR_BYTES, so "pointer full"
  // doubles as hdr_valid and rises the cycle after byte 79 is written.
  assign hdr_valid_o = (ptr_q == HDR_BYTES);
  assign wr_word_o   = ptr_q[6:2];
  assign wr_pos_o    = ptr_q[1:0];
  assign collide_o   = load_we_i && !load_clr_i && rq_i;
  assign wr_en_o     = load_we_i && !load_clr_i && !rq_i && (ptr_q < HDR_BYTES);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    ptr_d = ptr_q;
    if (load_clr_i)   ptr_d = '0;
    else if (wr_en_o) ptr_d = ptr_q + 7'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of block ordering.
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/header_server.sv
// Bus responder serving the 80-byte Bitcoin block header as 20 32-bit words
// (0..15 block 1, 16..19 block 2) over a rq/rdy read bus with 1-cycle latency.
// Word 19 is the byte-swapped nonce counter, stepped by nonce_inc.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   load_clr               pointer := 0, hdr_valid := 0, err := 0
//   load_we, load_byte     write one header byte at the load pointer
//   nonce_inc              nonce := nonce + 1 (wrapping)
//   rq, addr               read request and word address
//   data, rdy              read word and its valid flag
//   hdr_valid              full header loaded
//   nonce                  current nonce, numeric value
//   err                    sticky out-of-range read / write collision
module header_server
  import header_server_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_clr,
  input  logic        load_we,
  input  logic [7:0]  load_byte,
  input  logic        nonce_inc,
  input  logic        rq,
  input  logic [4:0]  addr,
  output logic [31:0] data,
  output logic        rdy,
  output logic        hdr_valid,
  output logic [31:0] nonce,
  output logic        err
);

  logic        wr_en, collide;
  logic [4:0]  wr_word;
  logic [1:0]  wr_pos;

  header_server_loader u_loader (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_clr_i  (load_clr),
    .load_we_i   (load_we),
    .rq_i        (rq),
    .wr_en_o     (wr_en),
    .wr_word_o   (wr_word),
    .wr_pos_o    (wr_pos),
    .collide_o   (collide),
    .hdr_valid_o (hdr_valid)
  );

  // Header words 0..18; word 19 comes from the nonce counter.
  logic [31:0] hdr_q [NONCE_WORD];

  // NOTE: the header array has no reset; its contents are undefined until
  // loaded, and leaving it out of reset keeps it a plain register file.
  always_ff @(posedge clk) begin
    if (wr_en && (wr_word < NONCE_WORD))
      hdr_q[wr_word][(3 - wr_pos)*8 +: 8] <= load_byte;  // byte 0 -> bits 31:24
  end

  logic [31:0] nonce_q, nonce_d;
  logic [31:0] data_q, data_d;
  logic [4:0]  addr_q, addr_d;
  logic        rdy_q, rdy_d;
  logic        err_q, err_d;
  logic [31:0] rd_word;
  logic        rd_oor;

  assign rd_oor = (addr >= HDR_WORDS);

  always_comb begin
    rd_word = '0;
    if (addr == NONCE_WORD)     rd_word = bswap32(nonce_q);
    else if (addr < NONCE_WORD) rd_word = hdr_q[addr];
  end

  always_comb begin
    // Nonce bytes are stored little-endian; a load of them beats an increment.
    nonce_d = nonce_q;
    if (wr_en && (wr_word == NONCE_WORD)) nonce_d[wr_pos*8 +: 8] = load_byte;
    else if (nonce_inc)                   nonce_d = nonce_q + 32'd1;

    // Read handshake: fetch when rdy is low, hold while the address is
    // unchanged, drop rdy for one cycle on an address change to refetch.
    data_d = data_q;
    addr_d = addr_q;
    rdy_d  = 1'b0;
    err_d  = err_q;
    if (rq) begin
      if (rdy_q) begin
        rdy_d = (addr == addr_q);
      end else begin
        data_d = rd_word;
        addr_d = addr;
        rdy_d  = 1'b1;
        if (rd_oor) err_d = 1'b1;
      end
    end
    if (collide)  err_d = 1'b1;
    if (load_clr) err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nonce_q <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      nonce_q <= nonce_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
    end
  end

  assign data  = data_q;
  assign rdy   = rdy_q;
  assign nonce = nonce_q;
  assign err   = err_q;

endmodule
